pong_key_sched: RTL

Controller between the PS/2 keyboard core and the pong game logic. It drains decoded key events from the core with the `data_ready`/`read` handshake and tracks which game keys are held. Once per video frame it issues one paddle-move command to each player, and it generates start and pause controls. It is the only block that drives the keyboard core's `read` input.

---
 rtl/pong_key_pkg.sv | 48 ++++
 rtl/pong_key_decode.sv | 30 +++
 rtl/pong_key_sched.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pong_key_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pong_key_pkg                                                         |
// | Shared constants, state encoding and move helper for pong key sched. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pong_key_pkg;

  localparam logic [7:0] KEY_W     = 8'h77;
  localparam logic [7:0] KEY_W_UC  = 8'h57;
  localparam logic [7:0] KEY_S     = 8'h73;
  localparam logic [7:0] KEY_S_UC  = 8'h53;
  localparam logic [7:0] KEY_UP    = 8'h92;
  localparam logic [7:0] KEY_DN    = 8'h93;
  localparam logic [7:0] KEY_SPACE = 8'h20;
  localparam logic [7:0] KEY_ESC   = 8'h1B;

  localparam logic [1:0] MV_NONE = 2'b00;
  localparam logic [1:0] MV_UP   = 2'b01;
  localparam logic [1:0] MV_DN   = 2'b10;

  // Bit positions inside the one-hot key select / held-key vector
  localparam int KEY_NUM   = 6;
  localparam int K_P1_UP   = 0;
  localparam int K_P1_DN   = 1;
  localparam int K_P2_UP   = 2;
  localparam int K_P2_DN   = 3;
  localparam int K_SPACE   = 4;
  localparam int K_ESC     = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } hs_state_t;

  function automatic logic [1:0] move_of(input logic up, input logic dn, input logic pause);
    logic [1:0] mv;
    mv = MV_NONE;
    if (!pause) begin
      if (up && !dn) mv = MV_UP;
      else if (dn && !up) mv = MV_DN;
    end
    return mv;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pong_key_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pong_key_decode                                                      |
// | Maps a translated key code to a one-hot game-key select.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pong_key_decode
  import pong_key_pkg::*;
(
  input  logic [7:0]         code,
  output logic [KEY_NUM-1:0] key_sel,
  output logic               known
);

  always_comb begin
    key_sel = '0;
    case (code)
      KEY_W, KEY_W_UC: key_sel[K_P1_UP] = 1'b1;
      KEY_S, KEY_S_UC: key_sel[K_P1_DN] = 1'b1;
      KEY_UP:          key_sel[K_P2_UP] = 1'b1;
      KEY_DN:          key_sel[K_P2_DN] = 1'b1;
      KEY_SPACE:       key_sel[K_SPACE] = 1'b1;
      KEY_ESC:         key_sel[K_ESC]   = 1'b1;
      default:         key_sel          = '0;
    endcase
    known = |key_sel;
  end

endmodule
`default_nettype wire

// File: rtl/pong_key_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pong_key_sched                                                       |
// | Drains PS/2 key events, tracks held game keys, issues paddle moves.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pong_key_sched
  import pong_key_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_ready,
  input  logic [7:0]           scancode,
  input  logic                 released,
  input  logic                 err_ind,
  output logic                 read,
  input  logic                 frame_tick,
  output logic [1:0]           p1_move,
  output logic [1:0]           p2_move,
  output logic                 start_pulse,
  output logic                 paused,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [ERR_CNT_W-1:0] c_err_one = 1;

  hs_state_t r_state;
  hs_state_t w_state_nxt;
  logic      w_read;
  logic      w_ack;

  logic [7:0]           r_code;
  logic                 r_rel;
  logic                 r_err;
  logic [KEY_NUM-1:0]   r_held;
  logic [KEY_NUM-1:0]   w_sel;
  logic                 w_known;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 r_start;
  logic                 r_paused;
  logic [1:0]           r_p1;
  logic [1:0]           r_p2;

  pong_key_decode u_decode (
    .code    (r_code),
    .key_sel (w_sel),
    .known   (w_known)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // WAIT is unconditional so a lagging data_ready cannot re-trigger the same event
  always_comb begin
    w_state_nxt = r_state;
    w_read      = 1'b0;
    case (r_state)
      ST_IDLE: if (data_ready) w_state_nxt = ST_ACK;
      ST_ACK: begin
        w_read      = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_ack = (r_state == ST_ACK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_code <= '0;
      r_rel  <= 1'b0;
      r_err  <= 1'b0;
    end else if (r_state == ST_IDLE && data_ready) begin
      r_code <= scancode;
      r_rel  <= released;
      r_err  <= err_ind;
    end
  end

  // Start and pause only react to edges of the held bit, so typematic repeats are inert
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_held    <= '0;
      r_err_cnt <= '0;
      r_start   <= 1'b0;
      r_paused  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (w_ack) begin
        if (r_err) begin
          if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + c_err_one;
        end else if (w_known) begin
          if (r_rel) begin
            r_held <= r_held & ~w_sel;
          end else begin
            r_held  <= r_held | w_sel;
            r_start <= w_sel[K_SPACE] & ~r_held[K_SPACE];
            if (w_sel[K_ESC] && !r_held[K_ESC]) r_paused <= ~r_paused;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p1 <= MV_NONE;
      r_p2 <= MV_NONE;
    end else if (frame_tick) begin
      r_p1 <= move_of(r_held[K_P1_UP], r_held[K_P1_DN], r_paused);
      r_p2 <= move_of(r_held[K_P2_UP], r_held[K_P2_DN], r_paused);
    end
  end

  assign read        = w_read;
  assign p1_move     = r_p1;
  assign p2_move     = r_p2;
  assign start_pulse = r_start;
  assign paused      = r_paused;
  assign err_cnt     = r_err_cnt;

endmodule
`default_nettype wire
